// File: rtl/obf_key_loader.sv
// obf_key_loader
// Serial-to-parallel activation key loader for the camouflaged c432 core.
// Receives KEY_WIDTH key bits (LSB first) plus one even-parity bit, verifies
// them and, on success, locks the key onto key_out until the next reset.
// A load can only succeed once per reset. Failed loads are counted, and after
// MAX_RETRY failures the block locks itself out permanently.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   load_start   one-cycle pulse that starts a key load
//   key_sdi      serial key data, LSB first, then the parity bit
//   key_sdi_vld  key_sdi qualifier
//   key_out      parallel key (bit0 -> s_0, bit1 -> s_1), KEY_RESET until locked
//   key_valid    key_out holds a verified key
//   key_err      last load attempt failed
//   lockout      retries exhausted, loads no longer accepted
//   busy         load in progress (SHIFT or CHECK)
module obf_key_loader #(
    parameter int                    KEY_WIDTH = 2,
    parameter logic [KEY_WIDTH-1:0]  KEY_RESET = '0,
    parameter int                    TIMEOUT   = 16,
    parameter int                    MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_sdi,
    input  logic                 key_sdi_vld,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 key_err,
    output logic                 lockout,
    output logic                 busy
);

    localparam int BW = $clog2(KEY_WIDTH + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(KEY_WIDTH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SHIFT  = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;
    localparam logic [2:0] ST_DEAD   = 3'd5;

    logic [2:0]           state;
    logic [KEY_WIDTH-1:0] shadow;
    logic                 parity;
    logic [BW-1:0]        bit_cnt;
    logic [IW-1:0]        idle_cnt;
    logic [RW-1:0]        retry_cnt;
    logic                 fail_now;

    // A failure is either a serial timeout or a parity mismatch; both take the
    // same ERROR/DEAD entry path below.
    always_comb begin
        fail_now = 1'b0;
        if (state == ST_SHIFT && !key_sdi_vld && idle_cnt == IDLE_LAST)
            fail_now = 1'b1;
        if (state == ST_CHECK && ((^shadow) ^ parity))
            fail_now = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_out   <= KEY_RESET;
            shadow    <= '0;
            parity    <= 1'b0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            lockout   <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                // A coincident data bit is dropped: the start wins.
                ST_IDLE, ST_ERROR: begin
                    if (load_start) begin
                        state    <= ST_SHIFT;
                        shadow   <= '0;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (key_sdi_vld) begin
                        idle_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            parity <= key_sdi;
                            state  <= ST_CHECK;
                        end else begin
                            for (int i = 0; i < KEY_WIDTH; i++)
                                if (bit_cnt == BW'(i)) shadow[i] <= key_sdi;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (!fail_now) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!fail_now) begin
                        state     <= ST_LOCKED;
                        key_out   <= shadow;
                        key_valid <= 1'b1;
                        key_err   <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ; // LOCKED and DEAD hold until reset
            endcase

            if (fail_now) begin
                key_err   <= 1'b1;
                busy      <= 1'b0;
                retry_cnt <= retry_cnt + 1'b1;
                if (retry_cnt + 1'b1 == RETRY_MAX) begin
                    state   <= ST_DEAD;
                    lockout <= 1'b1;
                end else begin
                    state   <= ST_ERROR;
                end
            end
        end
    end

endmodule

// File: tb/tb_obf_key_loader.sv
module tb_obf_key_loader;

    logic       clk = 1'b0;
    logic       rst_n, load_start, key_sdi, key_sdi_vld;
    logic [1:0] key_out;
    logic       key_valid, key_err, lockout, busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: outcome of whole load attempts, not cycles.
    logic [1:0] m_key;
    logic       m_valid, m_err, m_lock;
    int         m_fails;

    obf_key_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_sdi(key_sdi),
        .key_sdi_vld(key_sdi_vld), .key_out(key_out), .key_valid(key_valid),
        .key_err(key_err), .lockout(lockout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {key_out, key_valid, key_err, lockout, busy};
    endfunction

    function automatic logic [5:0] expv(input logic b);
        return {m_key, m_valid, m_err, m_lock, b};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load_start = 1'b0; key_sdi = 1'b0; key_sdi_vld = 1'b0;
        step();
        rst_n = 1'b1;
        m_key = 2'b00; m_valid = 1'b0; m_err = 1'b0; m_lock = 1'b0; m_fails = 0;
    endtask

    task automatic send_start(input logic vld, input logic d);
        load_start = 1'b1; key_sdi_vld = vld; key_sdi = d;
        step();
        load_start = 1'b0; key_sdi_vld = 1'b0;
    endtask

    task automatic send_bit(input logic d);
        key_sdi_vld = 1'b1; key_sdi = d;
        step();
        key_sdi_vld = 1'b0;
    endtask

    // Model of one load attempt's outcome.
    task automatic model_load(input logic [1:0] k, input logic p, input bit tmo);
        if (m_valid || m_lock) return;
        if (tmo || ((^k) ^ p)) begin
            m_err = 1'b1;
            m_fails++;
            if (m_fails == 3) m_lock = 1'b1;
        end else begin
            m_key = k; m_valid = 1'b1; m_err = 1'b0;
        end
    endtask

    // Full load: start, key bits with optional idle gaps, parity, CHECK cycle.
    task automatic run_load(input logic [1:0] k, input logic p, input int gap);
        send_start(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            repeat (gap) step();
            send_bit(k[i]);
        end
        repeat (gap) step();
        send_bit(p);
        step();
        model_load(k, p, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== 6'b00_0000) begin
            errors++; $display("FAIL reset: got %b want %b", obs(), 6'b00_0000);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        send_start(1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL nominal_check_cycle: valid=%b busy=%b want 0/1", key_valid, busy);
        end
        step();
        model_load(2'b01, 1'b1, 1'b0);
        checks++;
        if (obs() !== expv(1'b0) || key_out !== 2'b01) begin
            errors++; $display("FAIL nominal: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_parity_retry();
        do_reset();
        run_load(2'b11, 1'b1, 0);
        checks++;
        if (obs() !== expv(1'b0) || key_err !== 1'b1) begin
            errors++; $display("FAIL parity_fail: got %b want %b", obs(), expv(1'b0));
        end
        run_load(2'b10, 1'b1, 0);
        checks++;
        if (obs() !== expv(1'b0) || key_out !== 2'b10) begin
            errors++; $display("FAIL retry_pass: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_start(1'b0, 1'b0);
        send_bit(1'b1);
        repeat (15) step();
        checks++;
        if (busy !== 1'b1 || key_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: busy=%b err=%b want 1/0", busy, key_err);
        end
        step();
        model_load(2'b01, 1'b0, 1'b1);
        checks++;
        if (obs() !== expv(1'b0)) begin
            errors++; $display("FAIL timeout: got %b want %b", obs(), expv(1'b0));
        end
        // ERROR accepts a new load; a good key still passes after a timeout.
        run_load(2'b11, 1'b0, 0);
        checks++;
        if (obs() !== expv(1'b0)) begin
            errors++; $display("FAIL timeout_recover: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_lockout();
        do_reset();
        for (int i = 0; i < 3; i++) run_load(2'b01, 1'b0, 0);
        checks++;
        if (obs() !== expv(1'b0) || lockout !== 1'b1) begin
            errors++; $display("FAIL lockout: got %b want %b", obs(), expv(1'b0));
        end
        run_load(2'b01, 1'b1, 0);
        checks++;
        if (obs() !== expv(1'b0) || key_out !== 2'b00) begin
            errors++; $display("FAIL lockout_ignore: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_sticky();
        do_reset();
        run_load(2'b11, 1'b0, 0);
        send_start(1'b0, 1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); step();
        checks++;
        if (obs() !== expv(1'b0) || key_out !== 2'b11) begin
            errors++; $display("FAIL sticky: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_start(1'b0, 1'b0);
        send_bit(1'b1);
        do_reset();
        checks++;
        if (obs() !== 6'b00_0000) begin
            errors++; $display("FAIL midload_reset: got %b want %b", obs(), 6'b00_0000);
        end
        run_load(2'b10, 1'b1, 0);
        checks++;
        if (obs() !== expv(1'b0)) begin
            errors++; $display("FAIL midload_reload: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    // Data bit coincident with load_start is dropped.
    task automatic test_back_to_back();
        do_reset();
        send_start(1'b1, 1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); step();
        model_load(2'b10, 1'b1, 1'b0);
        checks++;
        if (obs() !== expv(1'b0)) begin
            errors++; $display("FAIL start_drop: got %b want %b", obs(), expv(1'b0));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [1:0] k;
            logic       p;
            int         gap;
            if (n % 4 == 0) do_reset();
            k   = 2'($urandom_range(0, 3));
            p   = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            run_load(k, p, gap);
            checks++;
            if (obs() !== expv(1'b0)) begin
                errors++; $display("FAIL random_%0d: k=%b p=%b got %b want %b", n, k, p, obs(), expv(1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_parity_retry();
        test_timeout();
        test_lockout();
        test_sticky();
        test_reset_midload();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
